// File: rtl/byte_inc_pkg.sv
// Shared constants and FSM encoding for the byte_inc read-increment-write engine.
package byte_inc_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_ADDR_WIDTH = 10;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT_DATA,
        WRITE
    } state_t;

endpackage

// File: rtl/byte_inc_word.sv
// Combinational per-byte +1 with byteenable generation for one bus word.
module byte_inc_word #(
    parameter int DATA_WIDTH = 64,
    parameter int BYTE_CNT   = DATA_WIDTH / 8,
    parameter int REM_W      = 3
) (
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  partial,
    input  logic [REM_W-1:0]      rem,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [BYTE_CNT-1:0]   byteenable
);

    // A partial last word enables only the low 'rem' bytes; disabled bytes pass through.
    for (genvar b = 0; b < BYTE_CNT; b++) begin : g_byte
        assign byteenable[b]     = !partial || (rem > REM_W'(b));
        assign wr_data[8*b +: 8] = byteenable[b] ? rd_data[8*b +: 8] + 8'd1 : rd_data[8*b +: 8];
    end

endmodule

// File: rtl/byte_inc.sv
// Walks a byte range word by word: read, increment every byte, write back to the same address.
module byte_inc
    import byte_inc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BYTE_CNT   = DATA_WIDTH / 8
) (
    input  logic                                 clk_i,
    input  logic                                 srst_i,
    input  logic [ADDR_WIDTH-1:0]                base_addr_i,
    input  logic [ADDR_WIDTH+$clog2(BYTE_CNT)-1:0] length_i,
    input  logic                                 run_i,
    output logic                                 waitrequest_o,
    output logic [ADDR_WIDTH-1:0]                amm_rd_address_o,
    output logic                                 amm_rd_read_o,
    input  logic [DATA_WIDTH-1:0]                amm_rd_readdata_i,
    input  logic                                 amm_rd_readdatavalid_i,
    input  logic                                 amm_rd_waitrequest_i,
    output logic [ADDR_WIDTH-1:0]                amm_wr_address_o,
    output logic                                 amm_wr_write_o,
    output logic [DATA_WIDTH-1:0]                amm_wr_writedata_o,
    output logic [BYTE_CNT-1:0]                  amm_wr_byteenable_o,
    input  logic                                 amm_wr_waitrequest_i
);

    localparam int LEN_W = ADDR_WIDTH + $clog2(BYTE_CNT);
    localparam int REM_W = (BYTE_CNT > 1) ? $clog2(BYTE_CNT) : 1;
    localparam int CNT_W = LEN_W + 1;

    state_t                state;
    logic [CNT_W-1:0]      words_left;
    logic [REM_W-1:0]      rem_q;
    logic [CNT_W-1:0]      word_cnt;
    logic [REM_W-1:0]      rem_in;
    logic [LEN_W:0]        len_round;
    logic                  last_word;
    logic                  partial;
    logic [DATA_WIDTH-1:0] inc_data;
    logic [BYTE_CNT-1:0]   inc_be;

    assign len_round = {1'b0, length_i} + (LEN_W+1)'(BYTE_CNT - 1);
    assign word_cnt  = CNT_W'(len_round / (LEN_W+1)'(BYTE_CNT));
    assign rem_in    = REM_W'(length_i % LEN_W'(BYTE_CNT));

    // Running off the top of the address space ends the job early, with a full word.
    assign last_word = (words_left == CNT_W'(1)) || (&amm_rd_address_o);
    assign partial   = (words_left == CNT_W'(1)) && (rem_q != '0);

    byte_inc_word #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_CNT   (BYTE_CNT),
        .REM_W      (REM_W)
    ) u_word (
        .rd_data    (amm_rd_readdata_i),
        .partial    (partial),
        .rem        (rem_q),
        .wr_data    (inc_data),
        .byteenable (inc_be)
    );

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state               <= IDLE;
            waitrequest_o       <= 1'b0;
            amm_rd_read_o       <= 1'b0;
            amm_rd_address_o    <= '0;
            amm_wr_write_o      <= 1'b0;
            amm_wr_address_o    <= '0;
            amm_wr_writedata_o  <= '0;
            amm_wr_byteenable_o <= '0;
            words_left          <= '0;
            rem_q               <= '0;
        end else begin
            case (state)
                IDLE: if (run_i) begin
                    state            <= READ;
                    waitrequest_o    <= 1'b1;
                    amm_rd_address_o <= base_addr_i;
                    amm_rd_read_o    <= (word_cnt != '0);
                    words_left       <= word_cnt;
                    rem_q            <= rem_in;
                end
                // An empty job passes through READ without a request, costing one busy cycle.
                READ: if (!amm_rd_read_o) begin
                    state         <= IDLE;
                    waitrequest_o <= 1'b0;
                end else if (!amm_rd_waitrequest_i) begin
                    amm_rd_read_o <= 1'b0;
                    state         <= WAIT_DATA;
                end
                WAIT_DATA: if (amm_rd_readdatavalid_i) begin
                    amm_wr_write_o      <= 1'b1;
                    amm_wr_address_o    <= amm_rd_address_o;
                    amm_wr_writedata_o  <= inc_data;
                    amm_wr_byteenable_o <= inc_be;
                    state               <= WRITE;
                end
                WRITE: if (!amm_wr_waitrequest_i) begin
                    amm_wr_write_o <= 1'b0;
                    if (last_word) begin
                        state         <= IDLE;
                        waitrequest_o <= 1'b0;
                    end else begin
                        state            <= READ;
                        amm_rd_read_o    <= 1'b1;
                        amm_rd_address_o <= amm_rd_address_o + ADDR_WIDTH'(1);
                        words_left       <= words_left - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_inc.sv
// Directed bench for byte_inc with a small Avalon-MM memory slave and stall generator.
module tb_byte_inc;

    logic        clk = 1'b0;
    logic        srst_i = 1'b1;
    logic [9:0]  base_addr_i = '0;
    logic [12:0] length_i = '0;
    logic        run_i = 1'b0;
    logic        waitrequest_o;
    logic [9:0]  amm_rd_address_o;
    logic        amm_rd_read_o;
    logic [63:0] amm_rd_readdata_i = '0;
    logic        amm_rd_readdatavalid_i = 1'b0;
    logic        amm_rd_waitrequest_i = 1'b0;
    logic [9:0]  amm_wr_address_o;
    logic        amm_wr_write_o;
    logic [63:0] amm_wr_writedata_o;
    logic [7:0]  amm_wr_byteenable_o;
    logic        amm_wr_waitrequest_i = 1'b0;

    always #5 clk = ~clk;

    byte_inc dut (
        .clk_i                  (clk),
        .srst_i                 (srst_i),
        .base_addr_i            (base_addr_i),
        .length_i               (length_i),
        .run_i                  (run_i),
        .waitrequest_o          (waitrequest_o),
        .amm_rd_address_o       (amm_rd_address_o),
        .amm_rd_read_o          (amm_rd_read_o),
        .amm_rd_readdata_i      (amm_rd_readdata_i),
        .amm_rd_readdatavalid_i (amm_rd_readdatavalid_i),
        .amm_rd_waitrequest_i   (amm_rd_waitrequest_i),
        .amm_wr_address_o       (amm_wr_address_o),
        .amm_wr_write_o         (amm_wr_write_o),
        .amm_wr_writedata_o     (amm_wr_writedata_o),
        .amm_wr_byteenable_o    (amm_wr_byteenable_o),
        .amm_wr_waitrequest_i   (amm_wr_waitrequest_i)
    );

    logic [63:0] mem  [0:1023];
    logic [63:0] orig [0:1023];
    int checks = 0;
    int errors = 0;

    // Slave behaviour: stall_mode 0 = no stalls, 1 = random, 2 = five cycles per request.
    int stall_mode = 0;
    int rd_lat = 0;
    int wr_count = 0, rd_count = 0, zero_hits = 0, stab_viol = 0;
    logic [63:0] last_wdata = '0;
    logic [7:0]  last_be = '0;
    bit          pend = 0;
    int          pcnt = 0;
    logic [9:0]  paddr = '0;
    int          rs_cnt = 0, ws_cnt = 0;
    bit          p_rd_stall = 0, p_wr_stall = 0;
    logic [9:0]  p_rd_addr = '0, p_wr_addr = '0;
    logic [63:0] p_wr_data = '0;
    logic [7:0]  p_wr_be = '0;

    always @(negedge clk) begin
        if (p_rd_stall && (!amm_rd_read_o || amm_rd_address_o != p_rd_addr)) stab_viol++;
        if (p_wr_stall && (!amm_wr_write_o || amm_wr_address_o != p_wr_addr ||
                           amm_wr_writedata_o != p_wr_data || amm_wr_byteenable_o != p_wr_be))
            stab_viol++;

        amm_rd_readdatavalid_i = 1'b0;
        if (pend) begin
            if (pcnt == 0) begin
                amm_rd_readdatavalid_i = 1'b1;
                amm_rd_readdata_i      = mem[paddr];
                pend = 0;
            end else pcnt--;
        end

        case (stall_mode)
            1: begin
                amm_rd_waitrequest_i = 1'($urandom_range(0, 1));
                amm_wr_waitrequest_i = 1'($urandom_range(0, 1));
            end
            2: begin
                if (amm_rd_read_o && rs_cnt < 5) begin amm_rd_waitrequest_i = 1'b1; rs_cnt++; end
                else begin amm_rd_waitrequest_i = 1'b0; rs_cnt = 0; end
                if (amm_wr_write_o && ws_cnt < 5) begin amm_wr_waitrequest_i = 1'b1; ws_cnt++; end
                else begin amm_wr_waitrequest_i = 1'b0; ws_cnt = 0; end
            end
            default: begin
                amm_rd_waitrequest_i = 1'b0;
                amm_wr_waitrequest_i = 1'b0;
            end
        endcase

        if (amm_rd_read_o && !amm_rd_waitrequest_i) begin
            pend = 1; pcnt = rd_lat; paddr = amm_rd_address_o; rd_count++;
            if (amm_rd_address_o == 10'd0) zero_hits++;
        end
        if (amm_wr_write_o && !amm_wr_waitrequest_i) begin
            for (int i = 0; i < 8; i++)
                if (amm_wr_byteenable_o[i]) mem[amm_wr_address_o][8*i +: 8] = amm_wr_writedata_o[8*i +: 8];
            last_wdata = amm_wr_writedata_o;
            last_be    = amm_wr_byteenable_o;
            wr_count++;
            if (amm_wr_address_o == 10'd0) zero_hits++;
        end

        p_rd_stall = amm_rd_read_o && amm_rd_waitrequest_i;
        p_rd_addr  = amm_rd_address_o;
        p_wr_stall = amm_wr_write_o && amm_wr_waitrequest_i;
        p_wr_addr  = amm_wr_address_o;
        p_wr_data  = amm_wr_writedata_o;
        p_wr_be    = amm_wr_byteenable_o;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic preload(input int base, input int n);
        for (int w = 0; w < n; w++) begin
            for (int i = 0; i < 8; i++) mem[base+w][8*i +: 8] = 8'(((base + w) * 8 + i) * 37 + 5);
            orig[base+w] = mem[base+w];
        end
    endtask

    // Issues a job and waits (bounded) for waitrequest_o to fall; reports the first busy sample.
    task automatic run_job(input logic [9:0] base, input logic [12:0] len, input int budget,
                           output bit first_busy, output int cyc, output bit timed_out);
        tick();
        base_addr_i = base; length_i = len; run_i = 1'b1;
        tick();
        run_i = 1'b0;
        first_busy = waitrequest_o;
        cyc = 0;
        while (waitrequest_o && cyc < budget) begin tick(); cyc++; end
        timed_out = waitrequest_o;
    endtask

    task automatic test_reset();
        srst_i = 1'b1;
        tick(); tick();
        checks++; if (waitrequest_o !== 1'b0) begin errors++; $display("FAIL reset_wreq: got %b expected 0", waitrequest_o); end
        checks++; if (amm_rd_read_o !== 1'b0) begin errors++; $display("FAIL reset_read: got %b expected 0", amm_rd_read_o); end
        checks++; if (amm_wr_write_o !== 1'b0) begin errors++; $display("FAIL reset_write: got %b expected 0", amm_wr_write_o); end
        checks++; if ({amm_rd_address_o, amm_wr_address_o, amm_wr_writedata_o, amm_wr_byteenable_o} !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h %h %h %h expected all 0",
                               amm_rd_address_o, amm_wr_address_o, amm_wr_writedata_o, amm_wr_byteenable_o);
        end
        srst_i = 1'b0;
        tick();
    endtask

    task automatic test_mvp();
        bit fb, to; int cyc, w0;
        for (int i = 0; i < 16; i++) mem[16 + i/8][8*(i%8) +: 8] = 8'(i);
        mem[10'h012] = 64'hDEAD_BEEF_0000_1111;
        w0 = wr_count;
        run_job(10'h010, 13'd16, 500, fb, cyc, to);
        checks++; if (fb !== 1'b1) begin errors++; $display("FAIL mvp_busy: got %b expected 1", fb); end
        checks++; if (to) begin errors++; $display("FAIL mvp_timeout: got busy after %0d cycles expected idle", cyc); end
        checks++; if (wr_count - w0 != 2) begin errors++; $display("FAIL mvp_writes: got %0d expected 2", wr_count - w0); end
        checks++; if (mem[10'h010] !== 64'h0807_0605_0403_0201) begin errors++; $display("FAIL mvp_word0: got %h expected 0807060504030201", mem[10'h010]); end
        checks++; if (mem[10'h011] !== 64'h100F_0E0D_0C0B_0A09) begin errors++; $display("FAIL mvp_word1: got %h expected 100f0e0d0c0b0a09", mem[10'h011]); end
        checks++; if (last_be !== 8'hFF) begin errors++; $display("FAIL mvp_be: got %h expected ff", last_be); end
        checks++; if (mem[10'h012] !== 64'hDEAD_BEEF_0000_1111) begin errors++; $display("FAIL mvp_next_word: got %h expected deadbeef00001111", mem[10'h012]); end
    endtask

    task automatic test_partial();
        bit fb, to; int cyc, w0;
        mem[10'h020] = '1;
        mem[10'h021] = 64'h1234_5678_9ABC_DEF0;
        w0 = wr_count;
        run_job(10'h020, 13'd3, 500, fb, cyc, to);
        checks++; if (to) begin errors++; $display("FAIL partial_timeout: got busy expected idle"); end
        checks++; if (wr_count - w0 != 1) begin errors++; $display("FAIL partial_writes: got %0d expected 1", wr_count - w0); end
        checks++; if (last_wdata !== 64'hFFFF_FFFF_FF00_0000) begin errors++; $display("FAIL partial_data: got %h expected ffffffffff000000", last_wdata); end
        checks++; if (last_be !== 8'h07) begin errors++; $display("FAIL partial_be: got %h expected 07", last_be); end
        checks++; if (mem[10'h021] !== 64'h1234_5678_9ABC_DEF0) begin errors++; $display("FAIL partial_next_word: got %h expected 123456789abcdef0", mem[10'h021]); end
    endtask

    task automatic test_len_zero();
        bit fb, to; int cyc, w0, r0;
        w0 = wr_count; r0 = rd_count;
        run_job(10'h030, 13'd0, 50, fb, cyc, to);
        checks++; if (fb !== 1'b1 || cyc != 1) begin errors++; $display("FAIL zero_len_timing: got busy=%b drop_after=%0d expected busy=1 drop_after=1", fb, cyc); end
        checks++; if (rd_count != r0 || wr_count != w0) begin errors++; $display("FAIL zero_len_bus: got rd=%0d wr=%0d expected 0 0", rd_count - r0, wr_count - w0); end
    endtask

    task automatic test_stall(input int mode, input logic [9:0] base);
        bit fb, to; int cyc, w0, s0;
        logic [63:0] exp;
        preload(base, 14);
        stall_mode = mode;
        w0 = wr_count; s0 = stab_viol;
        run_job(base, 13'd100, 5000, fb, cyc, to);
        stall_mode = 0;
        checks++; if (to) begin errors++; $display("FAIL stall%0d_timeout: got busy expected idle", mode); end
        checks++; if (wr_count - w0 != 13) begin errors++; $display("FAIL stall%0d_writes: got %0d expected 13", mode, wr_count - w0); end
        checks++; if (stab_viol != s0) begin errors++; $display("FAIL stall%0d_stable: got %0d violations expected 0", mode, stab_viol - s0); end
        checks++; if (last_be !== 8'h0F) begin errors++; $display("FAIL stall%0d_last_be: got %h expected 0f", mode, last_be); end
        for (int w = 0; w < 14; w++) begin
            exp = orig[base+w];
            for (int i = 0; i < 8; i++)
                if (w*8 + i < 100) exp[8*i +: 8] = orig[base+w][8*i +: 8] + 8'd1;
            checks++; if (mem[base+w] !== exp) begin errors++; $display("FAIL stall%0d_word%0d: got %h expected %h", mode, w, mem[base+w], exp); end
        end
    endtask

    task automatic test_oversize();
        bit fb, to; int cyc, w0, r0, z0;
        mem[10'h3FE] = 64'h00FF_1122_3344_55FE;
        mem[10'h3FF] = '1;
        mem[10'h000] = 64'hAAAA_5555_AAAA_5555;
        w0 = wr_count; r0 = rd_count; z0 = zero_hits;
        run_job(10'h3FE, 13'd1000, 500, fb, cyc, to);
        checks++; if (to) begin errors++; $display("FAIL oversize_timeout: got busy expected idle"); end
        checks++; if (wr_count - w0 != 2 || rd_count - r0 != 2) begin errors++; $display("FAIL oversize_count: got rd=%0d wr=%0d expected 2 2", rd_count - r0, wr_count - w0); end
        checks++; if (zero_hits != z0) begin errors++; $display("FAIL oversize_wrap: got %0d accesses to 0 expected 0", zero_hits - z0); end
        checks++; if (mem[10'h3FE] !== 64'h0100_1223_3445_56FF) begin errors++; $display("FAIL oversize_word0: got %h expected 01001223344556ff", mem[10'h3FE]); end
        checks++; if (mem[10'h3FF] !== 64'h0) begin errors++; $display("FAIL oversize_word1: got %h expected 0", mem[10'h3FF]); end
        checks++; if (last_be !== 8'hFF) begin errors++; $display("FAIL oversize_be: got %h expected ff", last_be); end
        checks++; if (mem[10'h000] !== 64'hAAAA_5555_AAAA_5555) begin errors++; $display("FAIL oversize_addr0: got %h expected aaaa5555aaaa5555", mem[10'h000]); end
    endtask

    task automatic test_max_latency();
        bit fb, to; int cyc, w0, bad;
        logic [63:0] exp;
        preload(10'h200, 9);
        rd_lat = 50;
        w0 = wr_count;
        run_job(10'h200, 13'd64, 2000, fb, cyc, to);
        rd_lat = 0;
        checks++; if (to) begin errors++; $display("FAIL latency_timeout: got busy expected idle"); end
        checks++; if (wr_count - w0 != 8) begin errors++; $display("FAIL latency_busy_until_done: got %0d writes at drop expected 8", wr_count - w0); end
        checks++; if (cyc < 8 * 51) begin errors++; $display("FAIL latency_duration: got %0d cycles expected at least 408", cyc); end
        bad = 0;
        for (int w = 0; w < 9; w++) begin
            exp = orig[10'h200 + w];
            for (int i = 0; i < 8; i++) if (w < 8) exp[8*i +: 8] = orig[10'h200 + w][8*i +: 8] + 8'd1;
            if (mem[10'h200 + w] !== exp) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL latency_memory: got %0d bad words expected 0", bad); end
    endtask

    task automatic test_reset_mid_job();
        bit fb, to; int cyc, w0, n;
        preload(10'h300, 8);
        w0 = wr_count;
        tick();
        base_addr_i = 10'h300; length_i = 13'd64; run_i = 1'b1;
        tick();
        run_i = 1'b0;
        n = 0;
        while (wr_count - w0 < 2 && n < 200) begin tick(); n++; end
        checks++; if (wr_count - w0 < 2) begin errors++; $display("FAIL midreset_progress: got %0d writes expected 2", wr_count - w0); end
        srst_i = 1'b1;
        tick();
        checks++; if ({waitrequest_o, amm_rd_read_o, amm_wr_write_o} !== 3'b000) begin
            errors++; $display("FAIL midreset_idle: got wreq/read/write=%b%b%b expected 000", waitrequest_o, amm_rd_read_o, amm_wr_write_o);
        end
        checks++; if ({amm_rd_address_o, amm_wr_address_o, amm_wr_byteenable_o} !== '0) begin
            errors++; $display("FAIL midreset_outputs: got %h %h %h expected 0", amm_rd_address_o, amm_wr_address_o, amm_wr_byteenable_o);
        end
        srst_i = 1'b0;
        repeat (5) tick();
        checks++; if (wr_count - w0 != 2 || mem[10'h302] !== orig[10'h302]) begin
            errors++; $display("FAIL midreset_abort: got %0d writes word2=%h expected 2 writes word2=%h", wr_count - w0, mem[10'h302], orig[10'h302]);
        end
        mem[10'h100] = 64'h0123_4567_89AB_CDEF;
        w0 = wr_count;
        run_job(10'h100, 13'd8, 500, fb, cyc, to);
        checks++; if (to || wr_count - w0 != 1) begin errors++; $display("FAIL midreset_next_job: got timeout=%b writes=%0d expected 0 1", to, wr_count - w0); end
        checks++; if (mem[10'h100] !== 64'h0224_4668_8AAC_CEF0) begin errors++; $display("FAIL midreset_next_data: got %h expected 022446688aaccef0", mem[10'h100]); end
        checks++; if (last_be !== 8'hFF) begin errors++; $display("FAIL midreset_next_be: got %h expected ff", last_be); end
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) begin mem[a] = '0; orig[a] = '0; end
        test_reset();
        test_mvp();
        test_partial();
        test_len_zero();
        test_stall(1, 10'h040);
        test_stall(2, 10'h080);
        test_oversize();
        test_max_latency();
        test_reset_mid_job();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
